// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: forward-select
// encodings, pipeline-control state encodings and the select priority helper.
package fwd_hazard_unit_pkg;

   // Operand source selects presented to the EXE stage.
   localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
   localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result now sitting in MEM
   localparam logic [1:0] FWD_WB  = 2'b10;  // value now sitting in WB

   // Pipeline control state, exposed on the top-level state port.
   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_STALL  = 2'b01,
      ST_FREEZE = 2'b10
   } state_t;

   // The nearer producer holds the younger value, so an EXE match beats
   // a MEM match for the same register.
   function automatic logic [1:0] pick_sel(input logic m_e, input logic m_m);
      logic [1:0] sel;
      sel = FWD_RF;
      if (m_e) begin
         sel = FWD_MEM;
      end else if (m_m) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand comparator: matches one ID-stage source register against the
// EXE and MEM destinations and proposes the forward select for that operand.
// An operand whose valid bit is low never matches. WB is not compared because
// the register file resolves WB writes within the same cycle.
module fwd_src_match
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] src,
   input  logic              vld,
   input  logic [REG_AW-1:0] exe_dest,
   input  logic              exe_wb_en,
   input  logic [REG_AW-1:0] mem_dest,
   input  logic              mem_wb_en,
   output logic              m_e,
   output logic              m_m,
   output logic [1:0]        sel_next
);

   // Stage matches and the proposed select, nearer stage first.
   always_comb begin
      m_e      = vld & exe_wb_en & (src == exe_dest);
      m_m      = vld & mem_wb_en & (src == mem_dest);
      sel_next = pick_sel(m_e, m_m);
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Combined forwarding-select generator and hazard detector for the ID stage.
// Checks NUM_SRC source operands against the EXE and MEM destinations,
// registers per-operand forward selects into the ID/EXE boundary, raises
// load-use (forwarding on) or any-dependency (forwarding off) stalls, and
// freezes while the data memory is not ready. Stall and freeze cycles are
// tallied in saturating counters.
//
// Flow control: mem_ready is a level-sensitive ready from the data memory.
// While it is low the whole pipeline holds (freeze=1); nothing here is
// transferred or counted as a stall in that cycle, and the registered
// forward selects keep their value so the frozen EXE instruction still sees
// the selects it was issued with.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW  = 4,
   parameter int NUM_SRC = 3,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      forward_EN,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_vld,
   input  logic                      exe_wb_en,
   input  logic                      exe_mem_r_en,
   input  logic [REG_AW-1:0]         exe_dest,
   input  logic                      mem_wb_en,
   input  logic [REG_AW-1:0]         mem_dest,
   input  logic                      mem_ready,
   input  logic                      clr_cnt,
   output logic                      hazard_stall,
   output logic                      freeze,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic [CNT_W-1:0]          freeze_cnt,
   output logic [1:0]                state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_SRC-1:0]   m_e;
   logic [NUM_SRC-1:0]   m_m;
   logic [2*NUM_SRC-1:0] sel_next;
   logic [2*NUM_SRC-1:0] fwd_sel_q;
   logic [CNT_W-1:0]     stall_cnt_q;
   logic [CNT_W-1:0]     freeze_cnt_q;
   state_t               state_q;
   state_t               state_d;
   logic                 stall_raw;

   // One comparator per source operand.
   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_match #(
         .REG_AW (REG_AW)
      ) u_match (
         .src       (id_src[gi*REG_AW +: REG_AW]),
         .vld       (id_src_vld[gi]),
         .exe_dest  (exe_dest),
         .exe_wb_en (exe_wb_en),
         .mem_dest  (mem_dest),
         .mem_wb_en (mem_wb_en),
         .m_e       (m_e[gi]),
         .m_m       (m_m[gi]),
         .sel_next  (sel_next[gi*2 +: 2])
      );
   end

   // Hazard detection: with forwarding only a load in EXE cannot be bypassed;
   // without forwarding any in-flight producer forces a stall. A freeze
   // already holds everything, so it masks the stall.
   always_comb begin
      freeze    = ~mem_ready;
      stall_raw = 1'b0;
      if (forward_EN) begin
         stall_raw = |(m_e & {NUM_SRC{exe_mem_r_en}});
      end else begin
         stall_raw = |(m_e | m_m);
      end
      hazard_stall = stall_raw & ~freeze;
   end

   // Forward selects for the instruction entering EXE next cycle; a stall
   // injects a bubble, which needs no forwarding.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_sel_q <= '0;
      end else if (freeze) begin
         fwd_sel_q <= fwd_sel_q;
      end else if (hazard_stall || !forward_EN) begin
         fwd_sel_q <= '0;
      end else begin
         fwd_sel_q <= sel_next;
      end
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next control state: freeze dominates stall, any transition is legal.
   always_comb begin
      state_d = ST_RUN;
      if (freeze) begin
         state_d = ST_FREEZE;
      end else if (hazard_stall) begin
         state_d = ST_STALL;
      end
   end

   // Stall-cycle counter, saturating; clear wins over increment.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         stall_cnt_q <= '0;
      end else if (hazard_stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   // Freeze-cycle counter, saturating; clear wins over increment.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         freeze_cnt_q <= '0;
      end else if (freeze && (freeze_cnt_q != CNT_MAX)) begin
         freeze_cnt_q <= freeze_cnt_q + 1'b1;
      end
   end

   assign fwd_sel    = fwd_sel_q;
   assign stall_cnt  = stall_cnt_q;
   assign freeze_cnt = freeze_cnt_q;
   assign state      = state_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a table of one-cycle vectors with
// hand-computed combinational and registered expectations, followed by
// hand-written multi-cycle sequences for counter saturation, clear priority
// and reset during a freeze. Counters are built 4 bits wide so saturation
// is reachable in a few cycles.
module tb_fwd_hazard_unit;

   localparam int REG_AW  = 4;
   localparam int NUM_SRC = 3;
   localparam int CNT_W   = 4;

   typedef struct {
      logic        rst;
      logic        fen;
      logic [11:0] src;
      logic [2:0]  vld;
      logic        ewb;
      logic        eld;
      logic [3:0]  edest;
      logic        mwb;
      logic [3:0]  mdest;
      logic        mrdy;
      logic        clr;
      logic        hs;
      logic        frz;
      logic [5:0]  fsel;
      logic [1:0]  st;
      logic [3:0]  scnt;
      logic [3:0]  fcnt;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic                      forward_EN;
   logic [NUM_SRC*REG_AW-1:0] id_src;
   logic [NUM_SRC-1:0]        id_src_vld;
   logic                      exe_wb_en;
   logic                      exe_mem_r_en;
   logic [REG_AW-1:0]         exe_dest;
   logic                      mem_wb_en;
   logic [REG_AW-1:0]         mem_dest;
   logic                      mem_ready;
   logic                      clr_cnt;
   logic                      hazard_stall;
   logic                      freeze;
   logic [2*NUM_SRC-1:0]      fwd_sel;
   logic [CNT_W-1:0]          stall_cnt;
   logic [CNT_W-1:0]          freeze_cnt;
   logic [1:0]                state;

   fwd_hazard_unit #(
      .REG_AW  (REG_AW),
      .NUM_SRC (NUM_SRC),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .forward_EN   (forward_EN),
      .id_src       (id_src),
      .id_src_vld   (id_src_vld),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .exe_dest     (exe_dest),
      .mem_wb_en    (mem_wb_en),
      .mem_dest     (mem_dest),
      .mem_ready    (mem_ready),
      .clr_cnt      (clr_cnt),
      .hazard_stall (hazard_stall),
      .freeze       (freeze),
      .fwd_sel      (fwd_sel),
      .stall_cnt    (stall_cnt),
      .freeze_cnt   (freeze_cnt),
      .state        (state)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp;
   int n_err;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic rst_i, input logic fen, input logic [11:0] src,
      input logic [2:0] vld, input logic ewb, input logic eld,
      input logic [3:0] edest, input logic mwb, input logic [3:0] mdest,
      input logic mrdy, input logic clr, input logic hs, input logic frz,
      input logic [5:0] fsel, input logic [1:0] st, input logic [3:0] scnt,
      input logic [3:0] fcnt);
      vec_t v;
      v.rst = rst_i; v.fen = fen; v.src = src; v.vld = vld;
      v.ewb = ewb; v.eld = eld; v.edest = edest; v.mwb = mwb;
      v.mdest = mdest; v.mrdy = mrdy; v.clr = clr;
      v.hs = hs; v.frz = frz; v.fsel = fsel; v.st = st;
      v.scnt = scnt; v.fcnt = fcnt;
      return v;
   endfunction

   // ---------------- driver ----------------
   // Called at a falling edge: drive inputs, check combinational outputs,
   // cross the rising edge, check registered outputs, return at falling edge.
   task automatic run_vec(input vec_t v, input int idx);
      rst          = v.rst;
      forward_EN   = v.fen;
      id_src       = v.src;
      id_src_vld   = v.vld;
      exe_wb_en    = v.ewb;
      exe_mem_r_en = v.eld;
      exe_dest     = v.edest;
      mem_wb_en    = v.mwb;
      mem_dest     = v.mdest;
      mem_ready    = v.mrdy;
      clr_cnt      = v.clr;
      #1;
      chk("hazard_stall", idx, {31'b0, hazard_stall}, {31'b0, v.hs});
      chk("freeze",       idx, {31'b0, freeze},       {31'b0, v.frz});
      @(posedge clk);
      #1;
      chk("fwd_sel",    idx, {26'b0, fwd_sel},    {26'b0, v.fsel});
      chk("state",      idx, {30'b0, state},      {30'b0, v.st});
      chk("stall_cnt",  idx, {28'b0, stall_cnt},  {28'b0, v.scnt});
      chk("freeze_cnt", idx, {28'b0, freeze_cnt}, {28'b0, v.fcnt});
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   vec_t vecs[16];

   initial begin
      vec_t v;
      logic [3:0] exp_f;
      logic [3:0] exp_s;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; forward_EN = 1'b1; id_src = '0; id_src_vld = '0;
      exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = '0;
      mem_wb_en = 1'b0; mem_dest = '0; mem_ready = 1'b1; clr_cnt = 1'b0;

      //           rst fen src      vld    ewb eld edest mwb mdest rdy clr | hs frz fsel       st  scnt fcnt
      // reset with arbitrary inputs (load-use present, then memory not ready)
      vecs[0]  = mk(1, 1, 12'h735, 3'b111, 1, 1, 4'd5, 0, 4'd0, 1, 0,  1, 0, 6'b000000, 2'd0, 4'd0, 4'd0);
      vecs[1]  = mk(1, 1, 12'h735, 3'b111, 1, 1, 4'd5, 0, 4'd0, 0, 0,  0, 1, 6'b000000, 2'd0, 4'd0, 4'd0);
      // ALU dependency, forwarding on: op0 from MEM next cycle
      vecs[2]  = mk(0, 1, 12'h005, 3'b001, 1, 0, 4'd5, 0, 4'd0, 1, 0,  0, 0, 6'b000001, 2'd0, 4'd0, 4'd0);
      // double match on op1: EXE wins
      vecs[3]  = mk(0, 1, 12'h030, 3'b010, 1, 0, 4'd3, 1, 4'd3, 1, 0,  0, 0, 6'b000100, 2'd0, 4'd0, 4'd0);
      // op0 from EXE, op1 from MEM
      vecs[4]  = mk(0, 1, 12'h046, 3'b011, 1, 0, 4'd6, 1, 4'd4, 1, 0,  0, 0, 6'b001001, 2'd0, 4'd0, 4'd0);
      // load-use on op2
      vecs[5]  = mk(0, 1, 12'h700, 3'b100, 1, 1, 4'd7, 0, 4'd0, 1, 0,  1, 0, 6'b000000, 2'd1, 4'd1, 4'd0);
      // the load has moved to MEM: op2 from WB
      vecs[6]  = mk(0, 1, 12'h700, 3'b100, 0, 0, 4'd0, 1, 4'd7, 1, 0,  0, 0, 6'b100000, 2'd0, 4'd1, 4'd0);
      // forwarding off, invalid operand never matches
      vecs[7]  = mk(0, 0, 12'h009, 3'b000, 1, 0, 4'd9, 0, 4'd0, 1, 0,  0, 0, 6'b000000, 2'd0, 4'd1, 4'd0);
      // forwarding off, valid match in EXE then in MEM
      vecs[8]  = mk(0, 0, 12'h009, 3'b001, 1, 0, 4'd9, 0, 4'd0, 1, 0,  1, 0, 6'b000000, 2'd1, 4'd2, 4'd0);
      vecs[9]  = mk(0, 0, 12'h009, 3'b001, 0, 0, 4'd0, 1, 4'd9, 1, 0,  1, 0, 6'b000000, 2'd1, 4'd3, 4'd0);
      // forwarding off, no match
      vecs[10] = mk(0, 0, 12'h009, 3'b001, 0, 0, 4'd0, 1, 4'd2, 1, 0,  0, 0, 6'b000000, 2'd0, 4'd3, 4'd0);
      // load a non-zero select, then freeze for 3 cycles on a pending load-use
      vecs[11] = mk(0, 1, 12'h005, 3'b001, 1, 0, 4'd5, 0, 4'd0, 1, 0,  0, 0, 6'b000001, 2'd0, 4'd3, 4'd0);
      vecs[12] = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 0, 0,  0, 1, 6'b000001, 2'd2, 4'd3, 4'd1);
      vecs[13] = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 0, 0,  0, 1, 6'b000001, 2'd2, 4'd3, 4'd2);
      vecs[14] = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 0, 0,  0, 1, 6'b000001, 2'd2, 4'd3, 4'd3);
      // memory ready again: the load-use stall now shows
      vecs[15] = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 1, 0,  1, 0, 6'b000000, 2'd1, 4'd4, 4'd3);

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         run_vec(vecs[i], i);
      end

      // Freeze counter saturation: 15 more freeze cycles from 3.
      exp_f = 4'd3;
      for (int k = 0; k < 15; k++) begin
         exp_f = (exp_f == 4'hF) ? 4'hF : exp_f + 4'd1;
         v = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 0, 0,
                0, 1, 6'b000000, 2'd2, 4'd4, exp_f);
         run_vec(v, 100 + k);
      end

      // Clear during freeze: clear wins over increment.
      v = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 0, 1,
             0, 1, 6'b000000, 2'd2, 4'd0, 4'd0);
      run_vec(v, 200);

      // Stall counter saturation over 17 load-use cycles.
      exp_s = 4'd0;
      for (int k = 0; k < 17; k++) begin
         exp_s = (exp_s == 4'hF) ? 4'hF : exp_s + 4'd1;
         v = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 1, 0,
                1, 0, 6'b000000, 2'd1, exp_s, 4'd0);
         run_vec(v, 300 + k);
      end

      // Clear during stall.
      v = mk(0, 1, 12'h008, 3'b001, 1, 1, 4'd8, 0, 4'd0, 1, 1,
             1, 0, 6'b000000, 2'd1, 4'd0, 4'd0);
      run_vec(v, 400);

      // Build up a non-zero select and some freeze count, then reset while frozen.
      v = mk(0, 1, 12'h046, 3'b011, 1, 0, 4'd6, 1, 4'd4, 1, 0,
             0, 0, 6'b001001, 2'd0, 4'd0, 4'd0);
      run_vec(v, 500);
      v = mk(0, 1, 12'h046, 3'b011, 1, 0, 4'd6, 1, 4'd4, 0, 0,
             0, 1, 6'b001001, 2'd2, 4'd0, 4'd1);
      run_vec(v, 501);
      v = mk(1, 1, 12'h046, 3'b011, 1, 0, 4'd6, 1, 4'd4, 0, 0,
             0, 1, 6'b000000, 2'd0, 4'd0, 4'd0);
      run_vec(v, 502);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-source EXE-stage forwarding unit. It merges forwarding-select generation and hazard detection into one block.
- Compares ID-stage source registers (up to NUM_SRC operands: Rn, Rm, Rs) against EXE- and MEM-stage destinations. It registers per-source forward selects into the ID/EXE boundary, raises load-use or no-forward stalls, and freezes on a slow memory.
- Holds saturating performance counters for stall and freeze cycles.

Parameters:
- REG_AW, 4, register-address width.
- NUM_SRC, 3, number of source operands checked per instruction (1..4).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- forward_EN  in  1  forwarding mode enable.
- id_src  in  NUM_SRC*REG_AW  ID-stage source addresses; operand i occupies bits [i*REG_AW +: REG_AW].
- id_src_vld  in  NUM_SRC  per-operand valid; an invalid operand never matches.
- exe_wb_en  in  1  instruction in EXE writes back.
- exe_mem_r_en  in  1  instruction in EXE is a load.
- exe_dest  in  REG_AW  EXE destination register.
- mem_wb_en  in  1  instruction in MEM writes back.
- mem_dest  in  REG_AW  MEM destination register.
- mem_ready  in  1  data memory ready; low means pipeline freeze.
- clr_cnt  in  1  synchronous clear of both counters.
- hazard_stall  out  1  combinational; hold PC and IF/ID, inject a bubble into ID/EXE.
- freeze  out  1  combinational; equals ~mem_ready.
- fwd_sel  out  2*NUM_SRC  registered per-operand select for EXE: 00 register file, 01 MEM-stage ALU result, 10 WB value.
- stall_cnt  out  CNT_W  number of hazard-stall cycles.
- freeze_cnt  out  CNT_W  number of freeze cycles.
- state  out  2  00 RUN, 01 STALL, 10 FREEZE.

Behaviour:
Match definitions (per operand i):
- mE[i] = id_src_vld[i] & id_src[i]==exe_dest & exe_wb_en.
- mM[i] = id_src_vld[i] & id_src[i]==mem_dest & mem_wb_en.
- No comparison is made against WB; the register file resolves WB writes within the same cycle.

Hazard stall (combinational):
- freeze=1 forces hazard_stall=0.
- forward_EN=1: hazard_stall = OR_i(mE[i] & exe_mem_r_en). This is the load-use case only.
- forward_EN=0: hazard_stall = OR_i(mE[i] | mM[i]).

Forward selects (registered, 1-cycle latency):
- The value computed at edge t is used by the same instruction in EXE during cycle t+1.
- rst: fwd_sel <= 0.
- freeze: fwd_sel holds.
- hazard_stall: fwd_sel <= 0 (bubble).
- forward_EN=0: fwd_sel <= 0.
- Otherwise, per operand: mE[i] -> 01 (the producer will be in MEM). Else mM[i] -> 10 (the producer will be in WB). Else 00.
- Nearer stage wins when both match.

State register:
- rst -> RUN.
- Next state: FREEZE if ~mem_ready; else STALL if hazard_stall; else RUN.
- Transitions between any pair of states are legal.

Counters:
- rst or clr_cnt -> 0. clr_cnt takes priority over increment in the same cycle.
- stall_cnt increments on cycles where hazard_stall=1.
- freeze_cnt increments on cycles where freeze=1.
- Both saturate at all-ones; no wrap.

Reset mid-operation:
- All outputs return to reset values on the next edge, regardless of freeze or stall.

Decomposition:
- Shared package: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; state encodings RUN/STALL/FREEZE.
- One sub-module: fwd_src_match. It is instantiated NUM_SRC times via generate. Inputs are src, vld, and the stage dests/enables; outputs are mE, mM and the next select.
- Counters stay inline.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> fwd_sel=0, stall_cnt=0, freeze_cnt=0, state=RUN.
- ALU dependency with forward_EN=1: id_src[0]=5, vld=001, exe_dest=5, exe_wb_en=1, exe_mem_r_en=0 -> hazard_stall=0; next cycle fwd_sel[1:0]=01.
- Double match: id_src[1]=3, exe_dest=3, mem_dest=3, both wb_en=1 -> fwd_sel[3:2]=01 (EXE wins).
- Load-use: exe_dest=7, exe_mem_r_en=1, id_src[2]=7 -> hazard_stall=1, next fwd_sel=0, stall_cnt=1, state=STALL. Next cycle the load is in MEM (mem_dest=7) -> fwd_sel[5:4]=10.
- Invalid operand and forward_EN=0: id_src[0]=9 with vld[0]=0 and exe_dest=9 -> no stall. With vld[0]=1 -> hazard_stall=1 while the match is in EXE or MEM, and fwd_sel stays 0.
- Freeze: mem_ready=0 for 3 cycles during a pending load-use -> hazard_stall=0, fwd_sel held, freeze_cnt=3, state=FREEZE. Then force the counter to all-ones with clr_cnt=0 -> it stays all-ones. Assert clr_cnt -> 0 next cycle.
